// File: rtl/rv_ctl_hs.sv
// Multicycle RISC-V control FSM with a ready/request memory handshake, bus timeout,
// illegal-instruction/bus-error trap, and cycle/retired-instruction counters.
module rv_ctl_hs #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memreq,
  output logic             memrw,
  output logic             pcsourse,
  output logic             pcwrite,
  output logic             pccen,
  output logic             irwrite,
  output logic             regwen,
  output logic             mdrwrite,
  output logic [1:0]       wbsel,
  output logic [1:0]       immsel,
  output logic [1:0]       asel,
  output logic [1:0]       bsel,
  output logic [3:0]       alusel,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic       PC_INC    = 1'b0;
  localparam logic       PC_ALU    = 1'b1;
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] IMM_I     = 2'd0;
  localparam logic [1:0] IMM_S     = 2'd1;
  localparam logic [1:0] IMM_B     = 2'd2;
  localparam logic [1:0] IMM_J     = 2'd3;
  localparam logic [1:0] IMM_L     = IMM_I;
  localparam logic [1:0] ALUA_REG  = 2'd0;
  localparam logic [1:0] ALUA_PCC  = 2'd1;
  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_IMM  = 2'd1;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH, DECODE, LSW_ADDR, LW_MEM, LW_WB, SW_MEM,
    RTYPE_ALU, ITYPE_ALU, ALU_WB, BR_EXEC, JAL_EXEC, TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_ILL
  } iclass_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               retire;
  logic               mem_state;
  logic               timeout;
  iclass_e            iclass;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    iclass = C_ILL;
    case (opcode)
      7'b0000011: if (funct3 == 3'b010) iclass = C_LW;
      7'b0100011: if (funct3 == 3'b010) iclass = C_SW;
      7'b0110011: iclass = C_R;
      7'b0010011: if (funct3 == 3'b000 || funct3 == 3'b100 ||
                      funct3 == 3'b110 || funct3 == 3'b111) iclass = C_I;
      7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) iclass = C_BR;
      7'b1101111: iclass = C_JAL;
      default:    iclass = C_ILL;
    endcase
  end

  assign mem_state = (state_q == FETCH) || (state_q == LW_MEM) || (state_q == SW_MEM);
  assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (wait_q == WAIT_MAX);

  // NOTE: every output and next-state value gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    memreq    = 1'b0;
    memrw     = 1'b0;
    pcsourse  = PC_INC;
    pcwrite   = 1'b0;
    pccen     = 1'b0;
    irwrite   = 1'b0;
    regwen    = 1'b0;
    mdrwrite  = 1'b0;
    wbsel     = WB_PC;
    immsel    = IMM_B;
    asel      = ALUA_REG;
    bsel      = ALUB_REG;
    alusel    = ALU_ADD;
    halted    = 1'b0;
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;

    // A waiting memory state either counts another wait cycle or gives up; the
    // counter falls back to zero whenever the state is left, so entry always starts clean.
    if (mem_state && !mem_ready) begin
      if (timeout) begin
        state_d   = TRAP;
        bus_err_d = 1'b1;
      end else if (MEM_TIMEOUT != 0) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    case (state_q)
      FETCH: begin
        memreq = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          pccen   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        asel = ALUA_PCC;
        bsel = ALUB_IMM;
        case (iclass)
          C_LW, C_SW: state_d = LSW_ADDR;
          C_R:        state_d = RTYPE_ALU;
          C_I:        state_d = ITYPE_ALU;
          C_BR:       state_d = BR_EXEC;
          C_JAL:      state_d = JAL_EXEC;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      LSW_ADDR: begin
        asel    = ALUA_REG;
        bsel    = ALUB_IMM;
        immsel  = (iclass == C_SW) ? IMM_S : IMM_L;
        state_d = (iclass == C_SW) ? SW_MEM : LW_MEM;
      end
      LW_MEM: begin
        memreq = 1'b1;
        if (mem_ready) begin
          mdrwrite = 1'b1;
          state_d  = LW_WB;
        end
      end
      LW_WB: begin
        wbsel   = WB_MDR;
        regwen  = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      SW_MEM: begin
        memreq = 1'b1;
        memrw  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      RTYPE_ALU: begin
        alusel  = {funct3, instr[30]};
        state_d = ALU_WB;
      end
      ITYPE_ALU: begin
        immsel  = IMM_I;
        bsel    = ALUB_IMM;
        alusel  = {funct3, 1'b0};
        state_d = ALU_WB;
      end
      ALU_WB: begin
        wbsel   = WB_ALUOUT;
        regwen  = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      BR_EXEC: begin
        alusel   = ALU_SUB;
        pcsourse = PC_ALU;
        pcwrite  = funct3[0] ? ~zero : zero;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      JAL_EXEC: begin
        asel     = ALUA_PCC;
        bsel     = ALUB_IMM;
        immsel   = IMM_J;
        pcsourse = PC_ALU;
        pcwrite  = 1'b1;
        regwen   = 1'b1;
        wbsel    = WB_PC;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      TRAP: begin
        halted  = 1'b1;
        state_d = TRAP;
      end
      default: state_d = TRAP;
    endcase
  end

  assign cycle_d   = (state_q != TRAP) ? cycle_q + CNT_W'(1) : cycle_q;
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_rv_ctl_hs.sv
// Directed bench for rv_ctl_hs: per-cycle expected strobe vectors go through a
// scoreboard queue; counters and flags are checked at instruction boundaries.
module tb_rv_ctl_hs;

  localparam logic       PC_INC    = 1'b0;
  localparam logic       PC_ALU    = 1'b1;
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] IMM_I     = 2'd0;
  localparam logic [1:0] IMM_S     = 2'd1;
  localparam logic [1:0] IMM_B     = 2'd2;
  localparam logic [1:0] IMM_J     = 2'd3;
  localparam logic [1:0] ALUA_REG  = 2'd0;
  localparam logic [1:0] ALUA_PCC  = 2'd1;
  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_IMM  = 2'd1;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_XORI = 32'h0000_4013;
  localparam logic [31:0] I_LW   = 32'h0000_A083;
  localparam logic [31:0] I_SW   = 32'h0000_2023;
  localparam logic [31:0] I_SUB  = 32'h4000_0033;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  typedef struct packed {
    logic       memreq, memrw, pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
    logic [1:0] wbsel, immsel, asel, bsel;
    logic [3:0] alusel;
    logic       illegal, bus_err, halted;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic        memreq, memrw, pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
  logic [1:0]  wbsel, immsel, asel, bsel;
  logic [3:0]  alusel;
  logic        illegal, bus_err, halted;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        w_memreq, w_memrw, w_pcsourse, w_pcwrite, w_pccen, w_irwrite, w_regwen, w_mdrwrite;
  logic [1:0]  w_wbsel, w_immsel, w_asel, w_bsel;
  logic [3:0]  w_alusel;
  logic        w_illegal, w_bus_err, w_halted;
  logic [3:0]  w_cycle_cnt, w_instret_cnt;

  sb_t  sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic f_ill  = 1'b0;
  logic f_berr = 1'b0;

  always #5 clk = ~clk;

  rv_ctl_hs dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .memreq(memreq), .memrw(memrw), .pcsourse(pcsourse), .pcwrite(pcwrite),
    .pccen(pccen), .irwrite(irwrite), .regwen(regwen), .mdrwrite(mdrwrite),
    .wbsel(wbsel), .immsel(immsel), .asel(asel), .bsel(bsel), .alusel(alusel),
    .illegal(illegal), .bus_err(bus_err), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  rv_ctl_hs #(.MEM_TIMEOUT(0), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .memreq(w_memreq), .memrw(w_memrw), .pcsourse(w_pcsourse), .pcwrite(w_pcwrite),
    .pccen(w_pccen), .irwrite(w_irwrite), .regwen(w_regwen), .mdrwrite(w_mdrwrite),
    .wbsel(w_wbsel), .immsel(w_immsel), .asel(w_asel), .bsel(w_bsel), .alusel(w_alusel),
    .illegal(w_illegal), .bus_err(w_bus_err), .halted(w_halted),
    .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
  );

  function automatic ctl_t e_def();
    ctl_t c;
    c = '0;
    c.pcsourse = PC_INC;
    c.wbsel    = WB_PC;
    c.immsel   = IMM_B;
    c.asel     = ALUA_REG;
    c.bsel     = ALUB_REG;
    c.alusel   = ALU_ADD;
    return c;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = e_def();
    c.memreq  = 1'b1;
    c.irwrite = rdy;
    c.pcwrite = rdy;
    c.pccen   = rdy;
    return c;
  endfunction

  function automatic ctl_t e_decode();
    ctl_t c = e_def();
    c.asel = ALUA_PCC;
    c.bsel = ALUB_IMM;
    return c;
  endfunction

  function automatic ctl_t e_addr(input logic is_sw);
    ctl_t c = e_def();
    c.bsel   = ALUB_IMM;
    c.immsel = is_sw ? IMM_S : IMM_I;
    return c;
  endfunction

  function automatic ctl_t e_mem(input logic wr, input logic rdy);
    ctl_t c = e_def();
    c.memreq   = 1'b1;
    c.memrw    = wr;
    c.mdrwrite = !wr && rdy;
    return c;
  endfunction

  function automatic ctl_t e_wb(input logic [1:0] sel);
    ctl_t c = e_def();
    c.wbsel  = sel;
    c.regwen = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_alu(input logic imm, input logic [3:0] op);
    ctl_t c = e_def();
    c.alusel = op;
    if (imm) begin
      c.immsel = IMM_I;
      c.bsel   = ALUB_IMM;
    end
    return c;
  endfunction

  function automatic ctl_t e_br(input logic pw);
    ctl_t c = e_def();
    c.alusel   = ALU_SUB;
    c.pcsourse = PC_ALU;
    c.pcwrite  = pw;
    return c;
  endfunction

  function automatic ctl_t e_jal();
    ctl_t c = e_def();
    c.asel     = ALUA_PCC;
    c.bsel     = ALUB_IMM;
    c.immsel   = IMM_J;
    c.pcsourse = PC_ALU;
    c.pcwrite  = 1'b1;
    c.regwen   = 1'b1;
    c.wbsel    = WB_PC;
    return c;
  endfunction

  function automatic ctl_t e_trap();
    ctl_t c = e_def();
    c.halted = 1'b1;
    return c;
  endfunction

  // One clock: queue the expectation, compare at the falling edge, advance past the rising edge.
  task automatic step(input string tag, input ctl_t e);
    sb_t  s;
    ctl_t obs;
    s.tag = tag;
    s.exp = e;
    s.exp.illegal = f_ill;
    s.exp.bus_err = f_berr;
    sb_q.push_back(s);
    @(negedge clk);
    obs = {memreq, memrw, pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite,
           wbsel, immsel, asel, bsel, alusel, illegal, bus_err, halted};
    s = sb_q.pop_front();
    n_cmp++;
    assert (obs === s.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; instr = I_ADDI; zero = 1'b0; mem_ready = 1'b0;
    step("reset_state", e_fetch(1'b0));
    chk("reset_cycle", cycle_cnt, 0);
    chk("reset_instret", instret_cnt, 0);
    rst = 1'b0;

    mem_ready = 1'b1;
    step("addi_fetch", e_fetch(1'b1));
    step("addi_decode", e_decode());
    step("addi_exec", e_alu(1'b1, 4'b0000));
    step("addi_wb", e_wb(WB_ALUOUT));
    chk("addi_cycle", cycle_cnt, 4);
    chk("addi_instret", instret_cnt, 1);

    instr = I_LW;
    step("lw_fetch", e_fetch(1'b1));
    step("lw_decode", e_decode());
    step("lw_addr", e_addr(1'b0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_wait", e_mem(1'b0, 1'b0));
    mem_ready = 1'b1;
    step("lw_mem_done", e_mem(1'b0, 1'b1));
    step("lw_wb", e_wb(WB_MDR));
    chk("lw_cycle", cycle_cnt, 12);
    chk("lw_instret", instret_cnt, 2);

    instr = I_BNE; zero = 1'b0;
    step("bne_fetch", e_fetch(1'b1));
    step("bne_decode", e_decode());
    step("bne_taken", e_br(1'b1));
    chk("bne_instret", instret_cnt, 3);

    instr = I_BEQ;
    step("beq_fetch", e_fetch(1'b1));
    step("beq_decode", e_decode());
    step("beq_not_taken", e_br(1'b0));
    chk("beq_instret", instret_cnt, 4);

    instr = I_SUB;
    step("sub_fetch", e_fetch(1'b1));
    step("sub_decode", e_decode());
    step("sub_exec", e_alu(1'b0, 4'b0001));
    step("sub_wb", e_wb(WB_ALUOUT));

    instr = I_JAL;
    step("jal_fetch", e_fetch(1'b1));
    step("jal_decode", e_decode());
    step("jal_exec", e_jal());

    instr = I_XORI;
    step("xori_fetch", e_fetch(1'b1));
    step("xori_decode", e_decode());
    step("xori_exec", e_alu(1'b1, 4'b1000));
    step("xori_wb", e_wb(WB_ALUOUT));
    chk("mix_cycle", cycle_cnt, 29);
    chk("mix_instret", instret_cnt, 7);

    instr = I_SW;
    step("sw_fetch", e_fetch(1'b1));
    step("sw_decode", e_decode());
    step("sw_addr", e_addr(1'b1));
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("sw_wait", e_mem(1'b1, 1'b0));
    mem_ready = 1'b1;
    step("sw_ready_on_timeout", e_mem(1'b1, 1'b1));
    chk("sw_late_cycle", cycle_cnt, 48);
    chk("sw_late_instret", instret_cnt, 8);

    instr = I_BAD;
    step("bad_fetch", e_fetch(1'b1));
    step("bad_decode", e_decode());
    f_ill = 1'b1;
    step("bad_trap", e_trap());
    step("bad_trap_hold", e_trap());
    chk("bad_cycle_frozen", cycle_cnt, 50);
    chk("bad_instret", instret_cnt, 8);

    rst = 1'b1; f_ill = 1'b0; mem_ready = 1'b0;
    step("rst_pulse", e_fetch(1'b0));
    rst = 1'b0;
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);

    instr = I_SW; mem_ready = 1'b1;
    step("swto_fetch", e_fetch(1'b1));
    step("swto_decode", e_decode());
    step("swto_addr", e_addr(1'b1));
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("swto_wait", e_mem(1'b1, 1'b0));
    f_berr = 1'b1;
    step("swto_trap", e_trap());
    step("swto_trap_hold", e_trap());
    step("swto_trap_hold2", e_trap());
    chk("swto_cycle_frozen", cycle_cnt, 19);
    chk("swto_instret", instret_cnt, 0);

    rst = 1'b1; f_berr = 1'b0;
    step("rst_pulse2", e_fetch(1'b0));
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step("fetch_wait", e_fetch(1'b0));
      if (i == 15) chk("wrap_cycle_15", {28'd0, w_cycle_cnt}, 15);
      if (i == 16) chk("wrap_cycle_0", {28'd0, w_cycle_cnt}, 0);
    end
    f_berr = 1'b1;
    step("fetch_timeout_trap", e_trap());
    step("fetch_timeout_hold", e_trap());
    chk("fetch_to_cycle", cycle_cnt, 16);
    chk("notimeout_halted", {31'd0, w_halted}, 0);
    chk("notimeout_memreq", {31'd0, w_memreq}, 1);
    chk("notimeout_cycle", {28'd0, w_cycle_cnt}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_ctl_hs.md
Name: rv_ctl_hs

Overview:
Multicycle RISC-V control plane, next generation: same datapath control strobes, plus a ready/request memory handshake with wait states and a parametrised bus timeout. Adds BNE and I-type ALU (ADDI/XORI/ORI/ANDI) support, an illegal-instruction/bus-error trap state, and cycle/retired-instruction counters. Sits between the instruction register/datapath and the unified memory port.

Parameters:
MEM_TIMEOUT, 15, max wait cycles in a memory state before bus error; 0 disables the timeout.
CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
instr  in  32  current IR contents.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current request this cycle.
memreq  out  1  memory request valid.
memrw  out  1  1 = write, 0 = read; meaningful only with memreq.
pcsourse  out  1  PC_INC / PC_ALU.
pcwrite, pccen, irwrite, regwen, mdrwrite  out  1 each  datapath strobes.
wbsel, immsel, asel, bsel  out  2 each  mux selects; encodings from params.inc.
alusel  out  4  ALU operation.
illegal  out  1  sticky: trapped on an unsupported opcode.
bus_err  out  1  sticky: trapped on a memory timeout.
halted  out  1  FSM is in TRAP.
cycle_cnt  out  CNT_W  cycles since reset, excluding TRAP.
instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset: state FETCH; wait counter, cycle_cnt, instret_cnt, illegal and bus_err all 0. Outputs are decoded from state, so during and right after reset memreq=1 and memrw=0. Every other strobe is at its default: pcsourse=PC_INC, wbsel=WB_PC, immsel=IMM_B, asel=ALUA_REG, bsel=ALUB_REG, alusel=ALU_ADD, all enables 0.
- Decode key is {instr[6:0], instr[14:12]}:
  - LW 0000011/010, SW 0100011/010
  - R-type 0110011/xxx
  - I-ALU 0010011 with funct3 000, 100, 110 or 111
  - BEQ 1100011/000, BNE 1100011/001
  - JAL 1101111/xxx
  - Anything else is illegal.
- FETCH: memreq=1, memrw=0. Hold until mem_ready. On the mem_ready cycle assert irwrite, pcwrite, pccen (PC_INC) and go to DECODE.
- DECODE: asel=ALUA_PCC, bsel=ALUB_IMM, immsel=IMM_B, ALU_ADD (branch target into ALUOut). Next state by key:
  - LW/SW -> LSW_ADDR
  - R -> RTYPE_ALU
  - I-ALU -> ITYPE_ALU
  - BEQ/BNE -> BR_EXEC
  - JAL -> JAL_EXEC
  - illegal -> TRAP and set illegal.
- LSW_ADDR: asel=REG, bsel=IMM, immsel=IMM_S for SW else IMM_L, ALU_ADD. Next LW_MEM or SW_MEM.
- LW_MEM: memreq=1, memrw=0. Wait for mem_ready; on that cycle mdrwrite=1, then LW_WB.
- LW_WB: wbsel=WB_MDR, regwen=1, then FETCH.
- SW_MEM: memreq=1, memrw=1. Wait for mem_ready, then FETCH.
- RTYPE_ALU: asel=REG, bsel=REG, alusel={instr[14:12], instr[30]}, then ALU_WB.
- ITYPE_ALU: immsel=IMM_I, asel=REG, bsel=IMM, alusel={instr[14:12], 1'b0}, then ALU_WB.
- ALU_WB: wbsel=WB_ALUOUT, regwen=1, then FETCH.
- BR_EXEC: asel=REG, bsel=REG, ALU_SUB, pcsourse=PC_ALU. pcwrite = zero for BEQ, ~zero for BNE. Then FETCH.
- JAL_EXEC: asel=PCC, bsel=IMM, immsel=IMM_J, ALU_ADD, pcsourse=PC_ALU, pcwrite=1, regwen=1, wbsel=WB_PC. Then FETCH.
- TRAP: all strobes at default, memreq=0, halted=1. Absorbing; only rst exits.
- Wait counter (clog2(MEM_TIMEOUT+1) bits):
  - Cleared on entry to FETCH, LW_MEM and SW_MEM.
  - Increments each cycle in those states without mem_ready.
  - When it equals MEM_TIMEOUT and mem_ready=0: go to TRAP, set bus_err, suppress all write strobes that cycle.
  - mem_ready on the same cycle as the timeout: ready wins, normal completion.
  - MEM_TIMEOUT=0: never times out.
- memreq stays high and memrw stays constant for the whole wait. Once raised, a request is never withdrawn before mem_ready, except on timeout.
- cycle_cnt increments every non-TRAP cycle and wraps modulo 2^CNT_W.
- instret_cnt increments on the cycle an instruction leaves for FETCH (LW_WB, SW_MEM on ready, ALU_WB, BR_EXEC, JAL_EXEC) and wraps modulo 2^CNT_W. Illegal instructions do not retire.
- Reset mid-wait: immediate return to the reset state; any in-flight memory request is abandoned.

Test Plan:
- Zero-wait ADDI x1,x0,5 (mem_ready tied 1) -> FETCH, DECODE, ITYPE_ALU, ALU_WB. alusel=0000, regwen=1 in cycle 4; instret_cnt=1, cycle_cnt=4.
- LW with mem_ready low for 3 cycles in LW_MEM -> memreq/memrw=0 held 4 cycles, exactly one mdrwrite pulse, then LW_WB with wbsel=WB_MDR.
- BNE with zero=0 -> pcwrite=1, pcsourse=PC_ALU. BEQ with zero=0 -> pcwrite=0. Both add 1 to instret_cnt.
- SW with mem_ready never asserted, MEM_TIMEOUT=15 -> 16 wait cycles, then halted=1, bus_err=1. cycle_cnt frozen thereafter; no write strobe in the timeout cycle.
- mem_ready asserted exactly on the timeout cycle -> normal completion, bus_err=0.
- Opcode 0x0000007F in DECODE -> TRAP, illegal=1, instret_cnt unchanged. rst pulse -> FETCH, all counters and flags 0. CNT_W=4 run of 16+ cycles shows cycle_cnt wrapping 15->0.
